// File: rtl/spi_flash_pkg.sv
// rtl/spi_flash_pkg.sv - shared opcodes, state encoding and constants for the SPI flash responder
// Contents:
//   OP_READ, OP_FAST_READ, OP_JEDEC  supported opcodes
//   DUMMY_BITS                       dummy clocks between address and data for fast read
//   state_t                          responder FSM state encoding
package spi_flash_pkg;

   localparam logic [7:0] OP_READ      = 8'h03;
   localparam logic [7:0] OP_FAST_READ = 8'h0B;
   localparam logic [7:0] OP_JEDEC     = 8'h9F;
   localparam int         DUMMY_BITS   = 8;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_CMD    = 3'd1,
      ST_ADDR   = 3'd2,
      ST_DUMMY  = 3'd3,
      ST_DATA   = 3'd4,
      ST_ID     = 3'd5,
      ST_IGNORE = 3'd6
   } state_t;

endpackage

// File: rtl/spi_pin_sync.sv
// rtl/spi_pin_sync.sv - SPI pin synchronizer with SCK edge and SS fall detection
// Ports:
//   clk, rst              system clock, synchronous active-high reset
//   sck, ss, mosi         asynchronous SPI pins from the master
//   sck_rise, sck_fall    1-cycle pulses on synced SCK edges
//   ss_sync, ss_fall      synced chip select (active-low) and its falling-edge pulse
//   mosi_sync             synced MOSI, valid alongside sck_rise
module spi_pin_sync #(
   parameter int SYNC_FF = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic sck,
   input  logic ss,
   input  logic mosi,
   output logic sck_rise,
   output logic sck_fall,
   output logic ss_sync,
   output logic ss_fall,
   output logic mosi_sync
);

   logic [SYNC_FF-1:0] sck_sr;
   logic [SYNC_FF-1:0] ss_sr;
   logic [SYNC_FF-1:0] mosi_sr;
   logic               sck_d;
   logic               ss_d;

   // SS resets low on purpose: a master already mid-frame when reset
   // releases must not look like a fresh SS fall.
   always_ff @(posedge clk) begin
      if (rst) begin
         sck_sr  <= '0;
         ss_sr   <= '0;
         mosi_sr <= '0;
         sck_d   <= 1'b0;
         ss_d    <= 1'b0;
      end else begin
         sck_sr  <= {sck_sr[SYNC_FF-2:0], sck};
         ss_sr   <= {ss_sr[SYNC_FF-2:0], ss};
         mosi_sr <= {mosi_sr[SYNC_FF-2:0], mosi};
         sck_d   <= sck_sr[SYNC_FF-1];
         ss_d    <= ss_sr[SYNC_FF-1];
      end
   end

   assign sck_rise  =  sck_sr[SYNC_FF-1] & ~sck_d;
   assign sck_fall  = ~sck_sr[SYNC_FF-1] &  sck_d;
   assign ss_sync   =  ss_sr[SYNC_FF-1];
   assign ss_fall   = ~ss_sr[SYNC_FF-1] &  ss_d;
   assign mosi_sync =  mosi_sr[SYNC_FF-1];

endmodule

// File: rtl/spi_flash_responder.sv
// rtl/spi_flash_responder.sv - SPI mode-0 flash emulator serving READ and JEDEC-ID from a byte memory
// Optional feature macro: SPI_FAST_READ_EN (accepts 0x0B with 8 dummy clocks)
// Ports:
//   i_clk, i_rst          sole clock, synchronous active-high reset
//   i_flash_sck/ss/mosi   SPI pins from master (SCK idle low, SS active-low)
//   o_flash_miso          responder data, changes on SCK fall
//   o_mem_addr, o_mem_rd  backing memory byte address and 1-cycle read strobe
//   i_mem_data            memory read data, valid the cycle after o_mem_rd
//   o_busy                frame in progress
//   o_cmd_err             1-cycle pulse on unsupported opcode
module spi_flash_responder
   import spi_flash_pkg::*;
#(
   parameter int          MEM_AW   = 11,
   parameter logic [23:0] JEDEC_ID = 24'hEF4015,
   parameter int          SYNC_FF  = 2
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_flash_sck,
   input  logic              i_flash_ss,
   input  logic              i_flash_mosi,
   output logic              o_flash_miso,
   output logic [MEM_AW-1:0] o_mem_addr,
   output logic              o_mem_rd,
   input  logic [7:0]        i_mem_data,
   output logic              o_busy,
   output logic              o_cmd_err
);

   logic sck_rise, sck_fall, ss_sync, ss_fall, mosi_sync;

   spi_pin_sync #(.SYNC_FF(SYNC_FF)) u_sync (
      .clk       (i_clk),
      .rst       (i_rst),
      .sck       (i_flash_sck),
      .ss        (i_flash_ss),
      .mosi      (i_flash_mosi),
      .sck_rise  (sck_rise),
      .sck_fall  (sck_fall),
      .ss_sync   (ss_sync),
      .ss_fall   (ss_fall),
      .mosi_sync (mosi_sync)
   );

   state_t            state, next_state;
   logic [4:0]        bit_cnt;
   logic [6:0]        rx;
   logic [7:0]        cmd_byte;
   logic [7:0]        tx;
   logic [MEM_AW-1:0] addr;
   logic [1:0]        id_idx;
   logic [7:0]        id_byte;
   logic              mem_rd, ld_mem, ld_id, cmd_err, miso;
   logic              req_mem, req_id, id_start, cmd_bad;
   logic              fast;

   assign cmd_byte = {rx, mosi_sync};

`ifdef SPI_FAST_READ_EN
   always_ff @(posedge i_clk) begin
      if (i_rst)
         fast <= 1'b0;
      else if (state == ST_CMD && next_state == ST_ADDR)
         fast <= (cmd_byte == OP_FAST_READ);
   end
`else
   assign fast = 1'b0;
`endif

   always_ff @(posedge i_clk) begin
      if (i_rst) state <= ST_IDLE;
      else       state <= next_state;
   end

   // Synced SS high overrides everything, including an SCK edge in the same cycle.
   always_comb begin
      next_state = state;
      req_mem    = 1'b0;
      req_id     = 1'b0;
      id_start   = 1'b0;
      cmd_bad    = 1'b0;
      if (ss_sync) begin
         next_state = ST_IDLE;
      end else begin
         case (state)
            // SS already low without a seen fall means we came out of reset mid-frame.
            ST_IDLE: next_state = ss_fall ? ST_CMD : ST_IGNORE;
            ST_CMD: begin
               if (sck_rise && bit_cnt[2:0] == 3'd7) begin
                  case (cmd_byte)
                     OP_READ: next_state = ST_ADDR;
`ifdef SPI_FAST_READ_EN
                     OP_FAST_READ: next_state = ST_ADDR;
`endif
                     OP_JEDEC: begin
                        next_state = ST_ID;
                        req_id     = 1'b1;
                        id_start   = 1'b1;
                     end
                     default: begin
                        next_state = ST_IGNORE;
                        cmd_bad    = 1'b1;
                     end
                  endcase
               end
            end
            ST_ADDR: begin
               if (sck_rise && bit_cnt == 5'd23) begin
                  if (fast) begin
                     next_state = ST_DUMMY;
                  end else begin
                     next_state = ST_DATA;
                     req_mem    = 1'b1;
                  end
               end
            end
            ST_DUMMY: begin
               if (sck_rise && bit_cnt == 5'(DUMMY_BITS - 1)) begin
                  next_state = ST_DATA;
                  req_mem    = 1'b1;
               end
            end
            ST_DATA:   req_mem = sck_rise && bit_cnt[2:0] == 3'd7;
            ST_ID:     req_id  = sck_rise && bit_cnt[2:0] == 3'd7;
            ST_IGNORE: next_state = ST_IGNORE;
            default:   next_state = ST_IDLE;
         endcase
      end
   end

   // Counts SCK rises within the current state; DATA/ID use the low 3 bits as a byte phase.
   always_ff @(posedge i_clk) begin
      if (i_rst || next_state != state) bit_cnt <= '0;
      else if (sck_rise)                bit_cnt <= bit_cnt + 5'd1;
   end

   always_comb begin
      case (id_idx)
         2'd0:    id_byte = JEDEC_ID[23:16];
         2'd1:    id_byte = JEDEC_ID[15:8];
         2'd2:    id_byte = JEDEC_ID[7:0];
         default: id_byte = 8'h00;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         rx      <= '0;
         tx      <= '0;
         addr    <= '0;
         id_idx  <= '0;
         mem_rd  <= 1'b0;
         ld_mem  <= 1'b0;
         ld_id   <= 1'b0;
         cmd_err <= 1'b0;
         miso    <= 1'b0;
      end else begin
         cmd_err <= cmd_bad;
         mem_rd  <= req_mem;
         ld_mem  <= mem_rd;
         ld_id   <= req_id;

         if (!ss_sync && sck_rise && state == ST_CMD)
            rx <= cmd_byte[6:0];

         // Shifting through MEM_AW bits drops the upper address bits for free.
         if (!ss_sync && sck_rise && state == ST_ADDR)
            addr <= {addr[MEM_AW-2:0], mosi_sync};
         else if (req_mem && state == ST_DATA)
            addr <= addr + {{(MEM_AW-1){1'b0}}, 1'b1};

         if (id_start)
            id_idx <= '0;
         else if (ld_id && id_idx != 2'd3)
            id_idx <= id_idx + 2'd1;

         if (ld_mem)
            tx <= i_mem_data;
         else if (ld_id)
            tx <= id_byte;
         else if (sck_fall && (state == ST_DATA || state == ST_ID))
            tx <= {tx[6:0], 1'b0};

         if (ss_sync || !(state == ST_DATA || state == ST_ID))
            miso <= 1'b0;
         else if (sck_fall)
            miso <= tx[7];
      end
   end

   assign o_flash_miso = miso;
   assign o_mem_addr   = addr;
   assign o_mem_rd     = mem_rd;
   assign o_cmd_err    = cmd_err;
   assign o_busy       = !ss_sync && (state == ST_CMD || state == ST_ADDR ||
                                      state == ST_DUMMY || state == ST_DATA ||
                                      state == ST_ID);

endmodule
